// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

  localparam int unsigned CntWidth     = 8;
  localparam int unsigned PerfCntWidth = 32;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    RUN,
    MEM_WAIT
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand EX forwarding select; the MEM producer wins over the WB producer.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic       use_i,
  input  logic [4:0] rd_m_i,
  input  logic [2:0] reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic [2:0] reg_write_w_i,
  output logic [1:0] fwd_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = use_i && (reg_write_m_i != 3'd0) && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i);
  assign hit_w = use_i && (reg_write_w_i != 3'd0) && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (hit_m) begin
      fwd_o = FWD_MEM;
    end else if (hit_w) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline stall/flush/forward control with a data-memory wait FSM and timeout.
// Optional perf counters are compiled in when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [1:0] RegReadE,
  input  logic [2:0] RegWriteE,
  input  logic [2:0] RegWriteM,
  input  logic [2:0] RegWriteW,
  input  logic       MemToRegE,
  input  logic       JalD,
  input  logic       BranchE,
  input  logic       JalrE,
  input  logic       mem_req_m,
  input  logic       mem_ready,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] Forward1E,
  output logic [1:0] Forward2E,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(MEM_TIMEOUT);

  hz_state_e           state_q, state_d;
  logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;

  logic       memstall;
  logic       load_use;
  logic       ctrl_flow;
  logic [1:0] fwd1;
  logic [1:0] fwd2;

  // Load-use in EX is decided without the EX write enable; the load flag already implies it.
  logic unused_reg_write_e;
  assign unused_reg_write_e = ^RegWriteE;

  assign memstall  = (state_q == RUN) ? (mem_req_m & ~mem_ready) : ~mem_ready;
  assign load_use  = MemToRegE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign ctrl_flow = BranchE | JalrE;

  hazard_fwd_sel u_fwd_rs1 (
    .rs_e_i        (Rs1E),
    .use_i         (RegReadE[1]),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd1)
  );

  hazard_fwd_sel u_fwd_rs2 (
    .rs_e_i        (Rs2E),
    .use_i         (RegReadE[0]),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd2)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_m && !mem_ready) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end
        wait_cnt_d = (wait_cnt_q == TimeoutVal) ? wait_cnt_q : wait_cnt_q + 1'b1;
        // A stuck access never leaves MEM_WAIT on its own; only the flag reports it.
        if (wait_cnt_d == TimeoutVal) begin
          mem_err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    Forward1E = FWD_RF;
    Forward2E = FWD_RF;
    if (!rst_n) begin
      // Segment registers load bubbles while the core is held in reset.
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      // A redirect squashes the ID instruction, so its load-use stall is moot.
      StallF    = load_use & ~ctrl_flow;
      StallD    = load_use & ~ctrl_flow;
      FlushD    = ctrl_flow | JalD;
      FlushE    = ctrl_flow | load_use;
      Forward1E = fwd1;
      Forward2E = fwd2;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PerfCntWidth-1:0] perf_stall_q, perf_stall_d;
  logic [PerfCntWidth-1:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {{(PerfCntWidth-1){1'b0}}, StallF};
    perf_flush_d = perf_flush_q + {{(PerfCntWidth-1){1'b0}}, FlushD | FlushE};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
